// File: rtl/alu_op_issue.sv
// -----------------------------------------------------------------------------
// alu_op_issue
//
// Issue stage in front of the structural ALU. Incoming {opcode, A, B}
// operations are buffered in a small FIFO and handed to the ALU one at a
// time through a registered output slot.
//
// Handshake rules (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. A producer holds its payload stable
// while valid is high and ready is low. Ready never depends on the valid of
// the same interface.
//
// The undefined opcode 4'b0101 is accepted but never queued. Instead it is
// counted in a saturating 8-bit counter.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            synchronous clear of queued and presented operations
//   in_valid/ready   upstream handshake
//   in_op/a/b        upstream operation
//   out_valid/ready  ALU-side handshake
//   control          opcode to the ALU decoder (registered)
//   operand_a/b      operands to the ALU units (registered)
//   illegal_count    number of dropped 4'b0101 opcodes, saturating at 255
//   busy             FIFO non-empty or output slot occupied
// -----------------------------------------------------------------------------
module alu_op_issue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       control,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [7:0]       illegal_count,
    output logic             busy
);

    localparam int         AW         = $clog2(DEPTH);
    localparam logic [3:0] OP_ILLEGAL = 4'b0101;
    localparam logic [AW:0] PTR_ONE   = 1;

    // FIFO storage; no reset needed, validity is tracked by the pointers.
    logic [3:0]       r_mem_op [DEPTH];
    logic [WIDTH-1:0] r_mem_a  [DEPTH];
    logic [WIDTH-1:0] r_mem_b  [DEPTH];

    // One extra pointer bit separates the full and empty cases.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    logic             r_out_valid;
    logic [3:0]       r_control;
    logic [WIDTH-1:0] r_operand_a;
    logic [WIDTH-1:0] r_operand_b;
    logic [7:0]       r_illegal_count;

    logic w_empty;
    logic w_full;
    logic w_in_ready;
    logic w_accept;
    logic w_write;
    logic w_drop;
    logic w_load;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Full blocks entry even when the output slot is draining this cycle.
    // The freed entry becomes usable one cycle later, which keeps in_ready
    // free of any out_ready path.
    assign w_in_ready = !w_full && !flush;
    assign w_accept   = in_valid && w_in_ready;
    assign w_write    = w_accept && (in_op != OP_ILLEGAL);
    assign w_drop     = w_accept && (in_op == OP_ILLEGAL);

    // Refill the output slot whenever it is free or being consumed.
    assign w_load     = !w_empty && (!r_out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem_op[r_wr_ptr[AW-1:0]] <= in_op;
            r_mem_a[r_wr_ptr[AW-1:0]]  <= in_a;
            r_mem_b[r_wr_ptr[AW-1:0]]  <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_out_valid     <= 1'b0;
            r_control       <= '0;
            r_operand_a     <= '0;
            r_operand_b     <= '0;
            r_illegal_count <= '0;
        end else begin
            // w_drop is already gated by flush through in_ready.
            if (w_drop && (r_illegal_count != 8'hFF)) begin
                r_illegal_count <= r_illegal_count + 8'd1;
            end

            if (flush) begin
                // Payload registers keep their last value on purpose.
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_out_valid <= 1'b0;
            end else begin
                if (w_write) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_load) begin
                    r_rd_ptr    <= r_rd_ptr + PTR_ONE;
                    r_out_valid <= 1'b1;
                    r_control   <= r_mem_op[r_rd_ptr[AW-1:0]];
                    r_operand_a <= r_mem_a[r_rd_ptr[AW-1:0]];
                    r_operand_b <= r_mem_b[r_rd_ptr[AW-1:0]];
                end else if (r_out_valid && out_ready) begin
                    // Consumed with nothing behind it: FIFO must be empty here.
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = r_out_valid;
    assign control       = r_control;
    assign operand_a     = r_operand_a;
    assign operand_b     = r_operand_b;
    assign illegal_count = r_illegal_count;
    assign busy          = !w_empty || r_out_valid;

endmodule

// File: doc/alu_op_issue.md
# alu_op_issue

Upstream issue stage for the structural ALU. It buffers incoming ALU operations ({opcode, A, B}) in a small FIFO and presents one operation at a time to the ALU control decoder and datapath through a registered valid/ready output. The stage filters the one undefined opcode (4'b0101) and counts occurrences of it. The ALU decoder consumes `control` combinationally, and the adder, bitwise and comparator units consume `operand_a` and `operand_b`.

## Interface
Parameters:
- WIDTH, 8: operand width in bits.
- DEPTH, 4: number of FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of queued and presented operations.
- in_valid  in  1  an upstream operation is present.
- in_ready  out  1  the stage can accept an operation this cycle.
- in_op  in  4  opcode, encoded as in the ALU decoder (0000 transfer … 1111 EQ).
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- out_valid  out  1  `control`, `operand_a` and `operand_b` hold a valid operation.
- out_ready  in  1  the ALU consumes the operation this cycle.
- control  out  4  opcode to the ALU decoder.
- operand_a  out  WIDTH  operand A to the ALU.
- operand_b  out  WIDTH  operand B to the ALU.
- illegal_count  out  8  number of dropped 4'b0101 opcodes; saturates at 255.
- busy  out  1  high when the FIFO is non-empty or out_valid is high.

## Operation
- **Reset values** (rst_n low, asynchronous): FIFO empty, read and write pointers 0, out_valid 0, control 0, operand_a 0, operand_b 0, illegal_count 0. After reset, in_ready is 1 and busy is 0.
- **FIFO**: DEPTH entries of {op, a, b}. Pointers are log2(DEPTH)+1 bits wide, so the extra bit distinguishes full from empty. Pointers wrap modulo 2·DEPTH.
- **in_ready** = !full && !flush. It is a registered-state function and never depends on in_valid.
- **Accept**: an operation is accepted when in_valid && in_ready.
  - If in_op ≠ 4'b0101, it is written at the write pointer and the write pointer increments.
  - If in_op = 4'b0101, it is not written and illegal_count increments, saturating at 8'hFF.
- **Full FIFO with a concurrent pop**: no write occurs, because in_ready is 0. The freed slot becomes available on the next cycle.
- **Output register load**: loads from the FIFO head when !empty && (!out_valid || out_ready). The read pointer increments on the same edge. out_valid is set to 1.
- **Output drain**: if out_valid && out_ready && empty, out_valid clears to 0. control and the operands hold their last values.
- **Output stall**: while out_valid && !out_ready, control, operand_a and operand_b are held bit-stable.
- **Flush**: flush high at a clock edge does the following:
  - empties the FIFO and sets both pointers to 0;
  - clears out_valid;
  - keeps control and the operands at their last values;
  - leaves illegal_count unchanged;
  - drops any concurrent write, because in_ready is 0.
- **Flush priority**: flush overrides load and drain on the same edge.

## Timing
- **Accept-to-present latency**: 2 cycles.
  - Operation accepted at edge N (FIFO previously empty, output register empty).
  - Output register loaded at edge N+1; out_valid is high in the cycle after edge N+1.
- **Throughput**: one operation per cycle while out_ready is held high and the FIFO is non-empty.
- **Capacity**: at most DEPTH+1 operations in flight (DEPTH in the FIFO plus one in the output register).
- **Combinational paths**: none from inputs to outputs. in_ready depends on flush combinationally only; all other outputs are registered.
- **Asynchronous reset mid-transfer**: all in-flight operations are discarded immediately. No output glitches high after rst_n deasserts.

## Test plan
- **Reset**: assert rst_n=0 mid-stream with the FIFO holding 3 entries → out_valid=0, control=0, operands=0, illegal_count=0, in_ready=1 and busy=0 immediately.
- **Latency and order**: push op=0010, a=8'h05, b=8'h03 at edge N, with out_ready=1 → out_valid=1 after edge N+1, showing control=0010, operand_a=05, operand_b=03. Then push 4 more ops back-to-back → they emerge one per cycle in order.
- **Full and backpressure**: with out_ready=0, push 6 ops → 5 are accepted and in_ready=0 after the 5th. The output holds op #1 stable. Raise out_ready for 1 cycle → op #2 is presented and in_ready=1 on the following cycle.
- **Illegal opcode**: push 0011, 0101, 0101, 1111 → the ALU sees only 0011 then 1111, and illegal_count=2. Push 300 illegal ops → illegal_count=255.
- **Flush**: with 3 queued ops, out_valid=1 and in_valid=1, pulse flush → the concurrent write is dropped, out_valid=0, busy=0 next cycle, and illegal_count is unchanged. The next pushed op appears 2 cycles after acceptance.
- **Pointer wrap**: stream 20 ops with out_ready randomly toggled → output order and values match the input order with illegal opcodes removed, and no loss or duplication.
